// File: rtl/mem_access_stage.sv
// MEM pipeline stage: turns EX/MEM loads/stores into a req/ack data-memory transaction and forms the MEM/WB writeback.
// Optional MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses and adds the misalign_err port.
module mem_access_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_plus_4_eo,
  input  logic [31:0] Read_data2_eo,
  input  logic [31:0] ALU_result_eo,
  input  logic [4:0]  Rd_eo,
  input  logic [1:0]  Wr_data_sel_eo,
  input  logic        Reg_wr_eo,
  input  logic        Mem_rd_eo,
  input  logic        Mem_wr_eo,
  input  logic [2:0]  Funct3_eo,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] Wr_data_mo,
  output logic [4:0]  Rd_mo,
  output logic        Reg_wr_mo,
  output logic        Mem_stall,
  output logic        bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
  // The 15th ack-less BUSY cycle sees the counter at 14 and aborts.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(14);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             mem_op_c, misalign_c, issue_c, done_c, timeout_c;

  logic             req_load;
  logic [2:0]       req_funct3;
  logic [1:0]       req_lo;
  logic [4:0]       req_rd;
  logic [1:0]       req_sel;
  logic             req_reg_wr;
  logic [XLEN-1:0]  req_alu, req_pc4;

  function automatic logic [XLEN-1:0] wb_mux(input logic [1:0] sel, input logic [XLEN-1:0] alu,
                                             input logic [XLEN-1:0] ld, input logic [XLEN-1:0] pc4);
    logic [XLEN-1:0] r;
    case (sel)
      2'b00:   r = alu;
      2'b01:   r = ld;
      2'b10:   r = pc4;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Funct3[1:0] selects size (00 byte, 01 half, else word); Funct3[2] selects zero-extension.
  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] w, input logic [1:0] lo,
                                                   input logic [2:0] f3);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = 8'(w >> {lo, 3'b000});
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   r = f3[2] ? XLEN'(b) : {{24{b[7]}}, b};
      2'b01:   r = f3[2] ? XLEN'(h) : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] r;
    case (f3[1:0])
      2'b00:   r = 4'b0001 << lo;
      2'b01:   r = lo[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  assign mem_op_c = Mem_rd_eo | Mem_wr_eo;

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign_c = 1'b0;
    case (Funct3_eo[1:0])
      2'b00:   misalign_c = 1'b0;
      2'b01:   misalign_c = ALU_result_eo[0];
      default: misalign_c = |ALU_result_eo[1:0];
    endcase
  end
`else
  assign misalign_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (issue_c) state_nx = BUSY;
      BUSY:    if (done_c || timeout_c) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM decode and the combinational upstream hold
  always_comb begin
    issue_c   = 1'b0;
    done_c    = 1'b0;
    timeout_c = 1'b0;
    Mem_stall = 1'b0;
    case (state)
      IDLE: begin
        issue_c   = mem_op_c && !misalign_c;
        Mem_stall = issue_c;
      end
      BUSY: begin
        done_c    = dmem_ack;
        timeout_c = !dmem_ack && (cnt == TIMEOUT_LAST);
        Mem_stall = !dmem_ack && !timeout_c;
      end
      default: ;
    endcase
    if (!reset) Mem_stall = 1'b0;
  end

  // Request launch, completion capture and MEM/WB outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_be      <= '0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      Wr_data_mo   <= '0;
      Rd_mo        <= '0;
      Reg_wr_mo    <= 1'b0;
      bus_err      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
      req_load     <= 1'b0;
      req_funct3   <= '0;
      req_lo       <= '0;
      req_rd       <= '0;
      req_sel      <= '0;
      req_reg_wr   <= 1'b0;
      req_alu      <= '0;
      req_pc4      <= '0;
    end else begin
      bus_err      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (issue_c) begin
            dmem_req   <= 1'b1;
            dmem_we    <= !Mem_rd_eo;
            dmem_addr  <= {ALU_result_eo[31:2], 2'b00};
            dmem_be    <= Mem_rd_eo ? 4'b1111 : store_be(Funct3_eo, ALU_result_eo[1:0]);
            dmem_wdata <= Mem_rd_eo ? '0 : store_data(Funct3_eo, Read_data2_eo);
            req_load   <= Mem_rd_eo;
            req_funct3 <= Funct3_eo;
            req_lo     <= ALU_result_eo[1:0];
            req_rd     <= Rd_eo;
            req_sel    <= Wr_data_sel_eo;
            req_reg_wr <= Reg_wr_eo && (Rd_eo != 5'd0);
            req_alu    <= ALU_result_eo;
            req_pc4    <= PC_plus_4_eo;
            Reg_wr_mo  <= 1'b0;
          end else if (mem_op_c) begin
            // Trapped misaligned access: bubble, no request
            Reg_wr_mo    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_err <= 1'b1;
`endif
          end else begin
            Wr_data_mo <= wb_mux(Wr_data_sel_eo, ALU_result_eo, '0, PC_plus_4_eo);
            Rd_mo      <= Rd_eo;
            Reg_wr_mo  <= Reg_wr_eo && (Rd_eo != 5'd0);
          end
        end
        BUSY: begin
          Reg_wr_mo <= 1'b0;
          if (done_c || timeout_c) begin
            cnt      <= '0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          if (done_c) begin
            Wr_data_mo <= wb_mux(req_sel, req_alu,
                                 req_load ? load_extract(dmem_rdata, req_lo, req_funct3) : '0,
                                 req_pc4);
            Rd_mo      <= req_rd;
            Reg_wr_mo  <= req_reg_wr;
          end
          if (timeout_c) bus_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected writebacks are queued at drive time and popped at completion.
// Honours MEM_MISALIGN_TRAP_EN when defined.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_plus_4_eo, Read_data2_eo, ALU_result_eo;
  logic [4:0]  Rd_eo;
  logic [1:0]  Wr_data_sel_eo;
  logic        Reg_wr_eo, Mem_rd_eo, Mem_wr_eo;
  logic [2:0]  Funct3_eo;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [31:0] Wr_data_mo;
  logic [4:0]  Rd_mo;
  logic        Reg_wr_mo, Mem_stall, bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        reg_wr;
    logic        chk_data;
    int          stalls;
    int          req_cyc;
    logic        berr;
    logic        trap;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .reset(reset),
    .PC_plus_4_eo(PC_plus_4_eo), .Read_data2_eo(Read_data2_eo), .ALU_result_eo(ALU_result_eo),
    .Rd_eo(Rd_eo), .Wr_data_sel_eo(Wr_data_sel_eo), .Reg_wr_eo(Reg_wr_eo),
    .Mem_rd_eo(Mem_rd_eo), .Mem_wr_eo(Mem_wr_eo), .Funct3_eo(Funct3_eo),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .Wr_data_mo(Wr_data_mo), .Rd_mo(Rd_mo), .Reg_wr_mo(Reg_wr_mo),
    .Mem_stall(Mem_stall), .bus_err(bus_err)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_err(misalign_err)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> {lo, 3'b000}) & 32'h0000_00FF;
    h = (w >> {lo[1], 4'b0000}) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    for (int i = 0; i < 4; i++) begin
      if (f3[1:0] == 2'b00)      be[i] = (2'(i) == lo);
      else if (f3[1:0] == 2'b01) be[i] = (i >= 2) == lo[1];
      else                       be[i] = 1'b1;
    end
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (f3[1:0] == 2'b01) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic model_trap(input logic is_mem, input logic [2:0] f3, input logic [1:0] lo);
`ifdef MEM_MISALIGN_TRAP_EN
    if (!is_mem || f3[1:0] == 2'b00) return 1'b0;
    if (f3[1:0] == 2'b01) return lo[0];
    return lo != 2'b00;
`else
    return 1'b0 & is_mem & f3[0] & lo[0];
`endif
  endfunction

  task automatic drive_nop();
    PC_plus_4_eo = '0; Read_data2_eo = '0; ALU_result_eo = '0; Rd_eo = '0;
    Wr_data_sel_eo = '0; Reg_wr_eo = 1'b0; Mem_rd_eo = 1'b0; Mem_wr_eo = 1'b0; Funct3_eo = '0;
  endtask

  // Called at a falling edge; returns at the falling edge after the writeback is visible.
  task automatic do_op(input string tag, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rd2, input logic [4:0] rd,
                       input logic [1:0] sel, input logic reg_wr, input logic [31:0] pc4,
                       input int ack_dly, input logic [31:0] rdata);
    exp_t        e;
    logic        is_mem, done, abort;
    logic [31:0] ld;
    int          stalls, reqc;
    is_mem     = rd_en | wr_en;
    e.trap     = model_trap(is_mem, f3, addr[1:0]);
    abort      = is_mem && (e.trap || ack_dly < 0);
    ld         = rd_en ? model_load(f3, addr[1:0], rdata) : 32'h0;
    e.data     = (sel == 2'b00) ? addr : (sel == 2'b01) ? ld : (sel == 2'b10) ? pc4 : 32'h0;
    e.rd       = rd;
    e.reg_wr   = reg_wr && (rd != 5'd0) && !abort;
    e.chk_data = !abort;
    e.req_cyc  = (!is_mem || e.trap) ? 0 : (ack_dly < 0 ? 15 : ack_dly + 1);
    e.stalls   = e.req_cyc;
    e.berr     = is_mem && !e.trap && ack_dly < 0;
    exp_q.push_back(e);

    ALU_result_eo = addr; Read_data2_eo = rd2; Rd_eo = rd; Wr_data_sel_eo = sel; Reg_wr_eo = reg_wr;
    Mem_rd_eo = rd_en; Mem_wr_eo = wr_en; Funct3_eo = f3; PC_plus_4_eo = pc4;
    dmem_ack = 1'b0;
    stalls = 0; reqc = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (e.req_cyc == 0) check_eq({tag, "_noreq"}, 32'(dmem_req), 32'h0);
      if (dmem_req) begin
        check_eq({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        check_eq({tag, "_we"}, 32'(dmem_we), 32'(!rd_en));
        check_eq({tag, "_be"}, 32'(dmem_be), rd_en ? 32'hF : 32'(model_be(f3, addr[1:0])));
        if (!rd_en) check_eq({tag, "_wdata"}, dmem_wdata, model_wdata(f3, rd2));
        if (reqc == ack_dly) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
        reqc++;
      end
      #1;
      if (Mem_stall) stalls++; else done = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      if (!done) @(negedge clk);
    end
    if (!done) check_eq({tag, "_wait_budget"}, 32'h0, 32'h1);

    e = exp_q.pop_front();
    check_eq({tag, "_reg_wr"}, 32'(Reg_wr_mo), 32'(e.reg_wr));
    if (e.chk_data) begin
      check_eq({tag, "_wdata_mo"}, Wr_data_mo, e.data);
      check_eq({tag, "_rd_mo"}, 32'(Rd_mo), 32'(e.rd));
    end
    check_eq({tag, "_stalls"}, 32'(stalls), 32'(e.stalls));
    check_eq({tag, "_req_cycles"}, 32'(reqc), 32'(e.req_cyc));
    check_eq({tag, "_bus_err"}, 32'(bus_err), 32'(e.berr));
    check_eq({tag, "_req_drop"}, 32'(dmem_req), 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    check_eq({tag, "_misalign"}, 32'(misalign_err), 32'(e.trap));
`endif
    @(negedge clk);
  endtask

  task automatic nop_cycle(input string tag);
    drive_nop();
    @(posedge clk); #1;
    check_eq({tag, "_bus_err_low"}, 32'(bus_err), 32'h0);
    check_eq({tag, "_req_low"}, 32'(dmem_req), 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    check_eq({tag, "_misalign_low"}, 32'(misalign_err), 32'h0);
`endif
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    drive_nop();
    repeat (2) @(negedge clk);
    check_eq("rst_req", 32'(dmem_req), 32'h0);
    check_eq("rst_reg_wr", 32'(Reg_wr_mo), 32'h0);
    check_eq("rst_wdata_mo", Wr_data_mo, 32'h0);
    check_eq("rst_be", 32'(dmem_be), 32'h0);
    check_eq("rst_bus_err", 32'(bus_err), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    do_op("alu", 1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd5, 2'b00, 1'b1, 32'h0, 0, 32'h0);
    check_eq("alu_lit", Wr_data_mo, 32'h1234_5678);
    do_op("lb", 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd10, 2'b01, 1'b1, 32'h0, 2, 32'h80FF_0000);
    check_eq("lb_lit", Wr_data_mo, 32'hFFFF_FF80);
    do_op("sh", 1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hAAAA_1234, 5'd0, 2'b00, 1'b0, 32'h0, 1, 32'h0);
    do_op("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_1001, 32'h0, 5'd4, 2'b01, 1'b1, 32'h0, 0, 32'h1234_F6AB);
    check_eq("lbu_lit", Wr_data_mo, 32'h0000_00F6);
    do_op("lh", 1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'h0, 5'd6, 2'b01, 1'b1, 32'h0, 3, 32'h9ABC_0000);
    check_eq("lh_lit", Wr_data_mo, 32'hFFFF_9ABC);
    do_op("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_1002, 32'h0, 5'd6, 2'b01, 1'b1, 32'h0, 0, 32'h9ABC_0000);
    check_eq("lhu_lit", Wr_data_mo, 32'h0000_9ABC);
    do_op("sb", 1'b0, 1'b1, 3'b000, 32'h0000_5001, 32'h0000_00A5, 5'd0, 2'b00, 1'b0, 32'h0, 0, 32'h0);
    do_op("sw_sel01", 1'b0, 1'b1, 3'b010, 32'h0000_6000, 32'hDEAD_BEEF, 5'd3, 2'b01, 1'b1, 32'h0, 1, 32'h0);
    do_op("lw_f3_110", 1'b1, 1'b0, 3'b110, 32'h0000_7004, 32'h0, 5'd8, 2'b01, 1'b1, 32'h0, 0, 32'h0BAD_F00D);
    do_op("pc4", 1'b0, 1'b0, 3'b000, 32'h0000_0010, 32'h0, 5'd1, 2'b10, 1'b1, 32'h0000_0104, 0, 32'h0);
    do_op("sel11", 1'b0, 1'b0, 3'b000, 32'h0000_0010, 32'h0, 5'd2, 2'b11, 1'b1, 32'h0000_0104, 0, 32'h0);
    do_op("rd0", 1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd0, 2'b00, 1'b1, 32'h0, 0, 32'h0);
    do_op("ack_on_last", 1'b1, 1'b0, 3'b010, 32'h0000_8000, 32'h0, 5'd9, 2'b01, 1'b1, 32'h0, 14, 32'h1357_9BDF);
    do_op("timeout", 1'b1, 1'b0, 3'b010, 32'h0000_9000, 32'h0, 5'd9, 2'b01, 1'b1, 32'h0, -1, 32'h0);
    nop_cycle("timeout_after");
    do_op("lw_3001", 1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 5'd12, 2'b01, 1'b1, 32'h0, 0, 32'hCAFE_BABE);
`ifndef MEM_MISALIGN_TRAP_EN
    check_eq("lw_3001_lit", Wr_data_mo, 32'hCAFE_BABE);
`endif
    nop_cycle("lw_3001_after");

    for (int i = 0; i < 12; i++) begin
      int          kind, pick;
      logic [2:0]  f3;
      kind = $urandom_range(0, 2);
      pick = $urandom_range(0, 4);
      case (pick)
        0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
      endcase
      if (kind == 2) f3 = 3'(pick % 3);
      do_op("rand", kind == 1, kind == 2, f3, $urandom, $urandom, 5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 4), $urandom);
    end

    // Abandon a transaction with reset, then offer a stale ack
    do_op("pre_rst", 1'b0, 1'b0, 3'b000, 32'h0000_0ABC, 32'h0, 5'd7, 2'b00, 1'b1, 32'h0, 0, 32'h0);
    Mem_rd_eo = 1'b1; Funct3_eo = 3'b010; ALU_result_eo = 32'h0000_4000; Rd_eo = 5'd7;
    Reg_wr_eo = 1'b1; Wr_data_sel_eo = 2'b01;
    repeat (3) @(negedge clk);
    check_eq("busy_req", 32'(dmem_req), 32'h1);
    reset = 1'b0; #1;
    check_eq("rst_mid_req", 32'(dmem_req), 32'h0);
    check_eq("rst_mid_stall", 32'(Mem_stall), 32'h0);
    check_eq("rst_mid_wdata_mo", Wr_data_mo, 32'h0);
    check_eq("rst_mid_rd_mo", 32'(Rd_mo), 32'h0);
    check_eq("rst_mid_addr", dmem_addr, 32'h0);
    @(negedge clk);
    drive_nop();
    reset = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check_eq("late_ack_reg_wr", 32'(Reg_wr_mo), 32'h0);
    check_eq("late_ack_wdata_mo", Wr_data_mo, 32'h0);
    check_eq("late_ack_req", 32'(dmem_req), 32'h0);
    @(negedge clk);
    do_op("post_rst", 1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd7, 2'b01, 1'b1, 32'h0, 1, 32'h2468_ACE0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
